// File: rtl/alu_rf_pkg.sv
// rtl/alu_rf_pkg.sv - shared op codes, opext codes, FSM encoding and op helpers
package alu_rf_pkg;

  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;
  localparam logic [3:0] OP_CMP = 4'h2;
  localparam logic [3:0] OP_AND = 4'h3;
  localparam logic [3:0] OP_OR  = 4'h4;
  localparam logic [3:0] OP_XOR = 4'h5;
  localparam logic [3:0] OP_MOV = 4'h6;

  localparam logic [3:0] OPC_RTYPE = 4'b0000;

  localparam logic [3:0] EXT_ADD = 4'b0101;
  localparam logic [3:0] EXT_SUB = 4'b1001;
  localparam logic [3:0] EXT_CMP = 4'b1011;
  localparam logic [3:0] EXT_AND = 4'b0001;
  localparam logic [3:0] EXT_OR  = 4'b0010;
  localparam logic [3:0] EXT_XOR = 4'b0011;
  localparam logic [3:0] EXT_MOV = 4'b1101;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DECODE = 2'd1,
    ST_WB     = 2'd2
  } state_t;

  function automatic logic writes_reg(input logic [3:0] op);
    return op != OP_CMP;
  endfunction

  function automatic logic updates_flags(input logic [3:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_CMP);
  endfunction

endpackage

// File: rtl/alu_rf_decoder.sv
// rtl/alu_rf_decoder.sv - combinational decode of a register-type instruction
module alu_rf_decoder
  import alu_rf_pkg::*;
(
  input  logic [15:0] instr,
  output logic [3:0]  alu_inst,
  output logic        legal,
  output logic        reg_we,
  output logic        flag_we
);

  logic ext_ok;

  // Unknown opext falls back to ADD so the ALU input is well defined while idle
  always_comb begin
    alu_inst = OP_ADD;
    ext_ok   = 1'b1;
    case (instr[7:4])
      EXT_ADD: alu_inst = OP_ADD;
      EXT_SUB: alu_inst = OP_SUB;
      EXT_CMP: alu_inst = OP_CMP;
      EXT_AND: alu_inst = OP_AND;
      EXT_OR:  alu_inst = OP_OR;
      EXT_XOR: alu_inst = OP_XOR;
      EXT_MOV: alu_inst = OP_MOV;
      default: ext_ok   = 1'b0;
    endcase
    legal   = (instr[15:12] == OPC_RTYPE) && ext_ok;
    reg_we  = legal && writes_reg(alu_inst);
    flag_we = legal && updates_flags(alu_inst);
  end

endmodule

// File: rtl/alu_rf_sequencer.sv
// rtl/alu_rf_sequencer.sv - instruction capture, decode and writeback sequencing for the ALU/RF
module alu_rf_sequencer
  import alu_rf_pkg::*;
#(
  parameter int CNT_W = 16,
  parameter int PSR_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             instr_valid,
  output logic             instr_ready,
  input  logic [15:0]      instr,
  output logic [3:0]       ra1,
  output logic [3:0]       ra2,
  output logic [3:0]       alu_inst,
  output logic             regwrite,
  input  logic [PSR_W-1:0] flag_in,
  output logic [PSR_W-1:0] psr,
  output logic             done,
  output logic             illegal,
  output logic [CNT_W-1:0] instr_count
);

  state_t      state;
  state_t      state_nx;
  logic [15:0] ir;
  logic        legal;
  logic        reg_we;
  logic        flag_we;

  alu_rf_decoder u_decoder (
    .instr    (ir),
    .alu_inst (alu_inst),
    .legal    (legal),
    .reg_we   (reg_we),
    .flag_we  (flag_we)
  );

  // Write address is ra1, so every op is Rdest <= Rdest op Rsrc
  assign ra1 = ir[11:8];
  assign ra2 = ir[3:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    instr_ready = 1'b0;
    regwrite    = 1'b0;
    done        = 1'b0;
    illegal     = 1'b0;
    case (state)
      ST_IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) state_nx = ST_DECODE;
      end
      ST_DECODE: begin
        if (legal) begin
          state_nx = ST_WB;
        end else begin
          illegal  = 1'b1;
          state_nx = ST_IDLE;
        end
      end
      ST_WB: begin
        done     = 1'b1;
        regwrite = reg_we;
        state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Flags are sampled in WB, before the write edge, so they reflect pre-write operands
  always_ff @(posedge clk) begin
    if (reset) begin
      ir          <= 16'h0000;
      psr         <= '0;
      instr_count <= '0;
    end else begin
      if ((state == ST_IDLE) && instr_valid) ir <= instr;
      if (state == ST_WB) begin
        instr_count <= instr_count + {{(CNT_W-1){1'b0}}, 1'b1};
        if (flag_we) psr <= flag_in;
      end
    end
  end

endmodule

// File: tb/tb_alu_rf_sequencer.sv
// tb/tb_alu_rf_sequencer.sv - randomized scoreboard bench for alu_rf_sequencer
module tb_alu_rf_sequencer;

  localparam int CNT_W = 4;
  localparam int PSR_W = 16;

  logic             clk = 1'b0;
  logic             reset;
  logic             instr_valid;
  logic             instr_ready;
  logic [15:0]      instr;
  logic [3:0]       ra1;
  logic [3:0]       ra2;
  logic [3:0]       alu_inst;
  logic             regwrite;
  logic [PSR_W-1:0] flag_in;
  logic [PSR_W-1:0] psr;
  logic             done;
  logic             illegal;
  logic [CNT_W-1:0] instr_count;

  alu_rf_sequencer #(.CNT_W(CNT_W), .PSR_W(PSR_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .ra1         (ra1),
    .ra2         (ra2),
    .alu_inst    (alu_inst),
    .regwrite    (regwrite),
    .flag_in     (flag_in),
    .psr         (psr),
    .done        (done),
    .illegal     (illegal),
    .instr_count (instr_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          ill;
    int          cyc;
    bit          rw;
    logic [3:0]  ra1;
    logic [3:0]  ra2;
    logic [3:0]  op;
    logic [15:0] psr_b;
    logic [15:0] psr_a;
    logic [3:0]  cnt_b;
    logic [3:0]  cnt_a;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic [15:0] m_psr = '0;
  logic [3:0]  m_cnt = '0;
  int          last_acc = 0;
  int          last_gap = 0;
  bit          chain = 0;
  logic [3:0]  ext_tab [7] = '{4'b0101, 4'b1001, 4'b1011, 4'b0001, 4'b0010, 4'b0011, 4'b1101};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Table position of the opext is the ALU op number (ADD=0 .. MOV=6)
  task automatic ref_decode(input logic [15:0] ins, output bit ok, output int op);
    ok = 0;
    op = 0;
    if (ins[15:12] == 4'h0)
      for (int i = 0; i < 7; i++)
        if (ext_tab[i] == ins[7:4]) begin
          ok = 1;
          op = i;
        end
  endtask

  function automatic logic [15:0] rand_legal();
    logic [3:0] ext;
    logic [3:0] rd;
    logic [3:0] rs;
    ext = ext_tab[$urandom_range(0, 6)];
    rd  = 4'($urandom);
    rs  = 4'($urandom);
    return {4'h0, rd, ext, rs};
  endfunction

  task automatic issue(input logic [15:0] ins, input bit hold, input bit nz);
    exp_t e;
    int   k;
    int   op;
    bit   ok;
    int   acc;
    instr       = ins;
    instr_valid = 1'b1;
    k = 0;
    while (!instr_ready && k < 10) begin
      @(negedge clk);
      k++;
    end
    if (!instr_ready) begin
      chk("ready_timeout", 0, 1);
      instr_valid = 1'b0;
      return;
    end
    flag_in = 16'($urandom);
    if (nz) flag_in[0] = 1'b1;
    acc = cyc + 1;
    if (chain) chk("accept_gap", acc - last_acc, last_gap);
    ref_decode(ins, ok, op);
    e.ill   = !ok;
    e.cyc   = ok ? acc + 1 : acc;
    e.rw    = ok && (op != 2);
    e.ra1   = ins[11:8];
    e.ra2   = ins[3:0];
    e.op    = 4'(op);
    e.psr_b = m_psr;
    e.cnt_b = m_cnt;
    e.psr_a = (ok && op <= 2) ? flag_in : m_psr;
    e.cnt_a = ok ? m_cnt + 4'd1 : m_cnt;
    q.push_back(e);
    m_psr    = e.psr_a;
    m_cnt    = e.cnt_a;
    last_acc = acc;
    last_gap = ok ? 3 : 2;
    chain    = hold;
    @(posedge clk);
    @(negedge clk);
    if (!hold) instr_valid = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_ready"}, instr_ready, 1);
    chk({tag, "_ra1"}, ra1, 0);
    chk({tag, "_ra2"}, ra2, 0);
    chk({tag, "_alu_inst"}, alu_inst, 0);
    chk({tag, "_regwrite"}, regwrite, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_illegal"}, illegal, 0);
    chk({tag, "_psr"}, psr, 0);
    chk({tag, "_count"}, instr_count, 0);
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b1;
    q.delete();
    chain = 0;
    m_psr = '0;
    m_cnt = '0;
    @(negedge clk);
    check_reset_vals(tag);
    reset = 1'b0;
  endtask

  // Monitor: pops one expectation per done/illegal cycle, then checks the post-edge state
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (!reset) begin
        if (!done) chk("regwrite_outside_wb", regwrite, 0);
        if (done || illegal) begin
          if (q.size() == 0) begin
            chk("unexpected_retire", {done, illegal}, 0);
          end else begin
            e = q.pop_front();
            chk("done", done, !e.ill);
            chk("illegal", illegal, e.ill);
            chk("regwrite", regwrite, e.rw);
            chk("ra1", ra1, e.ra1);
            chk("ra2", ra2, e.ra2);
            if (!e.ill) chk("alu_inst", alu_inst, e.op);
            chk("busy_ready", instr_ready, 0);
            chk("event_cycle", cyc, e.cyc);
            chk("psr_before", psr, e.psr_b);
            chk("count_before", instr_count, e.cnt_b);
            @(posedge clk);
            #1;
            if (!reset) begin
              chk("psr_after", psr, e.psr_a);
              chk("count_after", instr_count, e.cnt_a);
            end
          end
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog_timeout actual=running required=finished");
    $fatal(1);
  end

  initial begin
    reset       = 1'b1;
    instr_valid = 1'b0;
    instr       = 16'h0000;
    flag_in     = '0;
    repeat (2) @(negedge clk);
    check_reset_vals("reset");
    reset = 1'b0;

    issue(16'h0352, 0, 1);
    issue(16'h04B1, 0, 0);
    issue(16'h0352, 0, 1);
    issue(16'h0117, 0, 0);
    issue(16'h1352, 0, 0);
    issue(16'h0372, 0, 0);
    issue(16'h0D9A, 0, 0);
    issue(16'h02D3, 0, 0);

    for (int i = 0; i < 40; i++)
      issue(($urandom_range(0, 3) == 0) ? 16'($urandom) : rand_legal(), 0, 0);

    for (int i = 0; i < 30; i++)
      issue(($urandom_range(0, 4) == 0) ? 16'($urandom) : rand_legal(), 1, 0);
    instr_valid = 1'b0;
    repeat (4) @(negedge clk);

    do_reset("reset2");
    for (int i = 0; i < 16; i++) issue(rand_legal(), 0, 0);
    repeat (4) @(negedge clk);
    chk("count_wrap", instr_count, 0);

    issue(rand_legal(), 0, 0);
    issue(16'h0352, 0, 1);
    reset = 1'b1;
    q.delete();
    m_psr = '0;
    m_cnt = '0;
    chain = 0;
    @(negedge clk);
    check_reset_vals("rst_in_decode");
    reset = 1'b0;

    issue(rand_legal(), 0, 0);
    issue(16'h0352, 0, 1);
    @(negedge clk);
    chk("in_wb_done", done, 1);
    reset = 1'b1;
    q.delete();
    m_psr = '0;
    m_cnt = '0;
    chain = 0;
    @(negedge clk);
    check_reset_vals("rst_in_wb");
    reset = 1'b0;

    issue(16'h0459, 0, 1);
    repeat (6) @(negedge clk);
    chk("queue_empty", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
